eth_mii_tx_framer: RTL and testbench
====================================

// Module: eth_mii_tx_framer
// PURPOSE
//  Transmit-side MII (4-bit) framer for the ethernet_g test path; the TX counterpart of the nibble/dv capture on phy1.
//  Takes a byte stream from a valid/ready source and emits one nibble per clock on test_d[3:0]/test_dv-style outputs.
//  Each frame is sent as: preamble + SFD, payload, zero pad to the minimum length, CRC-32 FCS, then the inter-packet gap.
//  Underrun and oversize frames are aborted with TX_ER.
// PARAMETERS
//  PREAMBLE_NIBBLES  15    count of 0x5 nibbles before the SFD nibble 0xD
//  MIN_PAYLOAD       60    minimum bytes before FCS; shorter frames are zero-padded; 0 disables padding
//  MAX_PAYLOAD       1514  byte limit; accepting byte MAX_PAYLOAD+1 aborts the frame
//  IPG_NIBBLES       24    idle nibbles (tx_en=0) after every frame, aborted frames included
// PORTS
//  I_clk         in   1   nibble clock (25 MHz MII TXC domain); single clock
//  I_rst         in   1   reset: synchronous, active-high
//  I_s_data      in   8   payload byte (DA first)
//  I_s_valid     in   1   I_s_data valid
//  I_s_last      in   1   marks the final payload byte of the frame
//  O_s_ready     out  1   framer consumes the byte when I_s_valid&O_s_ready
//  O_tx_d        out  4   MII TXD
//  O_tx_en       out  1   MII TX_EN
//  O_tx_er       out  1   MII TX_ER; asserted only on abort
//  O_busy        out  1   high in every state except IDLE
//  O_frame_cnt   out  16  count of frames completed with good FCS; wraps 0xFFFF->0
//  O_abort_cnt   out  8   count of aborted frames; saturates at 0xFF
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, CRC=0xFFFFFFFF, counters 0. Every output is registered.
//  Reset mid-frame: outputs are 0 on the next cycle and the FSM returns to IDLE with no IPG; the partial frame is lost.
//  FSM states: IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IPG -> IDLE; abort path is DATA -> ABORT -> DRAIN -> IPG.
//  IDLE: O_s_ready=0. When I_s_valid=1 the FSM enters PRE; the first byte is held at the source.
//  PRE: PREAMBLE_NIBBLES cycles of tx_d=0x5, tx_en=1.
//  SFD: one cycle of tx_d=0xD. O_s_ready=1 in this cycle to fetch byte 0.
//  DATA: each byte takes 2 cycles, low nibble first.
//    O_s_ready=1 in the high-nibble cycle unless the current byte had I_s_last; this gives back-to-back bytes with no bubble.
//  Underrun: O_s_ready=1 with I_s_valid=0 -> ABORT.
//    ABORT = 2 cycles of tx_en=1, tx_er=1, tx_d=0; then tx_en=0.
//  Oversize: the (MAX_PAYLOAD+1)th byte is accepted, then handled as an abort.
//  DRAIN: tx_en=0, O_s_ready=1; bytes are discarded until a handshake with I_s_last=1, then IPG. No DRAIN if I_s_last was already seen.
//  PAD: entered when the last byte index+1 < MIN_PAYLOAD. Sends 0x00 bytes as nibbles 0,0 until MIN_PAYLOAD bytes are out; CRC covers the pad.
//  CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per nibble (4-bit step).
//    Covers payload and pad; preamble and SFD are excluded.
//  FCS: 8 cycles sending ~crc[3:0], ~crc[7:4], ... ~crc[31:28]. The CRC is frozen during FCS.
//  IPG: IPG_NIBBLES cycles of tx_en=0, tx_d=0.
//    O_frame_cnt increments on the IPG entry cycle for good frames only; O_abort_cnt increments on ABORT entry.
//  Simultaneous I_s_valid in the last IPG cycle: the FSM goes to IDLE, and PRE starts on the next cycle (1-cycle idle min).
//  The byte counter is 11 bits and is compared against MIN_PAYLOAD/MAX_PAYLOAD. The nibble counter is 5 bits and covers PRE/FCS/IPG.
//  A 1-byte frame still goes through the same path: SFD fetch, 2 DATA cycles, PAD (if enabled), FCS.
// STRUCTURE
//  eth_pkg: ETH_PREAMBLE_NIB=4'h5, ETH_SFD_NIB=4'hD, CRC32_POLY_R=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF,
//    tx_state_t enum {IDLE,PRE,SFD,DATA,PAD,FCS,ABORT,DRAIN,IPG}.
//  Sub-module eth_crc32_nib: comb next_crc = f(crc, nibble), 4 unrolled shift/xor steps.
//    The framer holds the CRC register and clear/enable control.
//  The top FSM, byte/nibble counters and output registers sit in this module.
// TESTING
//  1. MIN_PAYLOAD=0; send "123456789" (9 bytes, last on '9') -> 15x5, D, 1,3,2,3,...,9,3, then FCS nibbles 6,2,9,3,4,F,B,C (0xCBF43926).
//       Then 24 cycles tx_en=0; O_frame_cnt=1.
//  2. Default params; send a 1-byte frame 0xAA -> 59 pad bytes (118 zero nibbles).
//       tx_en high for exactly 16+120+8=144 cycles; the receiver-model CRC over data+FCS gives residue 0xDEBB20E3.
//  3. Two 64-byte frames with I_s_valid held high continuously -> gap between tx_en fall and rise is exactly 24+1 cycles.
//       No bubbles inside DATA; O_frame_cnt=2.
//  4. Drop I_s_valid at byte 10 for 1 cycle -> 2 cycles of tx_er=1 then tx_en=0.
//       Remaining bytes drained through I_s_last; O_abort_cnt=1, O_frame_cnt unchanged.
//  5. Send a 1515-byte frame -> abort after byte 1515 is accepted; DRAIN, IPG, then the next frame is sent normally.
//  6. Assert I_rst for 1 cycle in mid-DATA -> next cycle tx_en=tx_er=0, O_busy=0, counters=0; a new frame then starts clean.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the MII transmit framer.
// Holds the preamble/SFD nibble values, the reflected CRC-32 constants,
// the framer state encoding and a single-bit CRC shift helper.
package eth_pkg;

  localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY_R     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    PRE   = 4'd1,
    SFD   = 4'd2,
    DATA  = 4'd3,
    PAD   = 4'd4,
    FCS   = 4'd5,
    ABORT = 4'd6,
    DRAIN = 4'd7,
    IPG   = 4'd8
  } tx_state_t;

  // One bit of the LSB-first CRC-32 shift register.
  function automatic logic [31:0] crc32_bit_step(input logic [31:0] crc);
    crc32_bit_step = crc[0] ? ((crc >> 1) ^ CRC32_POLY_R) : (crc >> 1);
  endfunction

endpackage

// File: rtl/eth_crc32_nib.sv
// Combinational CRC-32 update for one MII nibble (LSB first).
// Ports:
//   crc_i  in  32  current CRC register
//   nib_i  in  4   nibble being transmitted
//   crc_o  out 32  CRC after absorbing nib_i
module eth_crc32_nib
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] crc_o
);

  logic [31:0] step0_s;
  logic [31:0] step1_s;
  logic [31:0] step2_s;
  logic [31:0] step3_s;

  // The nibble is folded into the low bits, then four shift/xor steps.
  assign step0_s = crc32_bit_step(crc_i ^ {28'h0000000, nib_i});
  assign step1_s = crc32_bit_step(step0_s);
  assign step2_s = crc32_bit_step(step1_s);
  assign step3_s = crc32_bit_step(step2_s);
  assign crc_o   = step3_s;

endmodule

// File: rtl/eth_mii_tx_framer.sv
// MII (4-bit) transmit framer: preamble+SFD, payload, zero pad, CRC-32 FCS, IPG.
// Underrun and oversize frames are cut short with TX_ER and the rest drained.
// Ports:
//   I_clk, I_rst                 nibble clock, synchronous active-high reset
//   I_s_data/valid/last, O_s_ready  byte source handshake (DA first)
//   O_tx_d, O_tx_en, O_tx_er     MII transmit pins
//   O_busy                       high whenever the FSM is not IDLE
//   O_frame_cnt                  good frames sent (wraps)
//   O_abort_cnt                  aborted frames (saturates)
module eth_mii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBBLES = 15,
  parameter int unsigned MIN_PAYLOAD      = 60,
  parameter int unsigned MAX_PAYLOAD      = 1514,
  parameter int unsigned IPG_NIBBLES      = 24
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [7:0]  I_s_data,
  input  logic        I_s_valid,
  input  logic        I_s_last,
  output logic        O_s_ready,
  output logic [3:0]  O_tx_d,
  output logic        O_tx_en,
  output logic        O_tx_er,
  output logic        O_busy,
  output logic [15:0] O_frame_cnt,
  output logic [7:0]  O_abort_cnt
);

  localparam logic [4:0]  PRE_LAST   = 5'(PREAMBLE_NIBBLES - 1);
  localparam logic [4:0]  IPG_LAST   = 5'(IPG_NIBBLES - 1);
  localparam logic [4:0]  FCS_LAST   = 5'd7;
  localparam logic [4:0]  ABORT_LAST = 5'd1;
  localparam logic [10:0] MIN_BYTES  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_BYTES  = 11'(MAX_PAYLOAD);

  tx_state_t   state_q, state_d;
  logic [4:0]  nib_q, nib_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        phase_q, phase_d;      // 0: low nibble cycle, 1: high nibble cycle
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;
  logic [3:0]  tx_d_q, tx_d_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        hs_s;
  logic [3:0]  data_nib_s;
  logic [3:0]  crc_nib_in_s;
  logic [31:0] crc_next_s;
  logic [31:0] crc_inv_s;

  assign hs_s = I_s_valid & ready_q;

  eth_crc32_nib u_crc (
    .crc_i (crc_q),
    .nib_i (crc_nib_in_s),
    .crc_o (crc_next_s)
  );

  // FSM, byte/nibble counters and frame/abort statistics.
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    byte_cnt_d  = byte_cnt_q;
    phase_d     = phase_q;
    byte_d      = byte_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (I_s_valid) begin
          state_d = PRE;
          nib_d   = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (nib_q == PRE_LAST) begin
          state_d    = SFD;
          byte_cnt_d = 11'd0;
          last_d     = 1'b0;
        end else begin
          nib_d = nib_q + 5'd1;
        end
      end
      // SFD and the DATA high-nibble cycle are the byte fetch points.
      SFD, DATA: begin
        if ((state_q == DATA) && !phase_q) begin
          phase_d = 1'b1;
        end else if ((state_q == DATA) && last_q) begin
          phase_d = 1'b0;
          nib_d   = 5'd0;
          if (byte_cnt_q < MIN_BYTES) begin
            state_d = PAD;
          end else begin
            state_d = FCS;
          end
        end else if (hs_s) begin
          byte_d     = I_s_data;
          last_d     = I_s_last;
          byte_cnt_d = byte_cnt_q + 11'd1;
          phase_d    = 1'b0;
          nib_d      = 5'd0;
          // The byte just taken is one past the limit: abort instead of sending it.
          if (byte_cnt_q == MAX_BYTES) begin
            state_d = ABORT;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = ABORT;
          nib_d   = 5'd0;
        end
      end
      PAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          byte_cnt_d = byte_cnt_q + 11'd1;
          if ((byte_cnt_q + 11'd1) >= MIN_BYTES) begin
            state_d = FCS;
            nib_d   = 5'd0;
          end else begin
            state_d = PAD;
          end
        end
      end
      FCS: begin
        if (nib_q == FCS_LAST) begin
          state_d = IPG;
          nib_d   = 5'd0;
        end else begin
          nib_d = nib_q + 5'd1;
        end
      end
      ABORT: begin
        if (nib_q == ABORT_LAST) begin
          nib_d   = 5'd0;
          state_d = last_q ? IPG : DRAIN;
        end else begin
          nib_d = nib_q + 5'd1;
        end
      end
      DRAIN: begin
        if (hs_s && I_s_last) begin
          state_d = IPG;
          nib_d   = 5'd0;
        end else begin
          state_d = DRAIN;
        end
      end
      IPG: begin
        if (nib_q == IPG_LAST) begin
          state_d = IDLE;
        end else begin
          nib_d = nib_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == FCS) && (state_d == IPG)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    if ((state_d == ABORT) && (state_q != ABORT) && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      abort_cnt_d = abort_cnt_q;
    end
  end

  // Output values for the cycle being entered, so every pin comes from a flop.
  always_comb begin
    tx_d_d       = 4'h0;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    ready_d      = 1'b0;
    busy_d       = (state_d != IDLE);
    data_nib_s   = phase_d ? byte_d[7:4] : byte_d[3:0];
    crc_nib_in_s = (state_d == PAD) ? 4'h0 : data_nib_s;
    crc_inv_s    = ~crc_q;
    case (state_d)
      PRE: begin
        tx_d_d  = ETH_PREAMBLE_NIB;
        tx_en_d = 1'b1;
      end
      SFD: begin
        tx_d_d  = ETH_SFD_NIB;
        tx_en_d = 1'b1;
        ready_d = 1'b1;
      end
      DATA: begin
        tx_d_d  = data_nib_s;
        tx_en_d = 1'b1;
        ready_d = phase_d & ~last_d;
      end
      PAD: begin
        tx_en_d = 1'b1;
      end
      FCS: begin
        tx_d_d  = crc_inv_s[{nib_d[2:0], 2'b00} +: 4];
        tx_en_d = 1'b1;
      end
      ABORT: begin
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
      end
      DRAIN: begin
        ready_d = 1'b1;
      end
      default: begin
        tx_d_d = 4'h0;
      end
    endcase

    // CRC absorbs exactly the nibble loaded onto TXD; it is frozen through FCS.
    if (state_d == PRE) begin
      crc_d = CRC32_INIT;
    end else if ((state_d == DATA) || (state_d == PAD)) begin
      crc_d = crc_next_s;
    end else begin
      crc_d = crc_q;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= IDLE;
      nib_q       <= 5'd0;
      byte_cnt_q  <= 11'd0;
      phase_q     <= 1'b0;
      byte_q      <= 8'h00;
      last_q      <= 1'b0;
      crc_q       <= CRC32_INIT;
      frame_cnt_q <= 16'd0;
      abort_cnt_q <= 8'd0;
      tx_d_q      <= 4'h0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      byte_cnt_q  <= byte_cnt_d;
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      tx_d_q      <= tx_d_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign O_s_ready   = ready_q;
  assign O_tx_d      = tx_d_q;
  assign O_tx_en     = tx_en_q;
  assign O_tx_er     = tx_er_q;
  assign O_busy      = busy_q;
  assign O_frame_cnt = frame_cnt_q;
  assign O_abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Self-checking bench for eth_mii_tx_framer: two instances (default parameters,
// and padding disabled), random payloads, expected nibble streams built from a
// byte-level frame model, receiver-side CRC residue check.
module tb_eth_mii_tx_framer;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       sel;          // 0: default instance, 1: no-pad instance

  logic        valid_a, ready_a, en_a, er_a, busy_a;
  logic [3:0]  txd_a;
  logic [15:0] fcnt_a;
  logic [7:0]  acnt_a;
  logic        valid_b, ready_b, en_b, er_b, busy_b;
  logic [3:0]  txd_b;
  logic [15:0] fcnt_b;
  logic [7:0]  acnt_b;

  assign valid_a = s_valid & ~sel;
  assign valid_b = s_valid & sel;

  eth_mii_tx_framer u_dut (
    .I_clk(clk), .I_rst(rst), .I_s_data(s_data), .I_s_valid(valid_a), .I_s_last(s_last),
    .O_s_ready(ready_a), .O_tx_d(txd_a), .O_tx_en(en_a), .O_tx_er(er_a), .O_busy(busy_a),
    .O_frame_cnt(fcnt_a), .O_abort_cnt(acnt_a)
  );

  eth_mii_tx_framer #(.MIN_PAYLOAD(0)) u_dut_nopad (
    .I_clk(clk), .I_rst(rst), .I_s_data(s_data), .I_s_valid(valid_b), .I_s_last(s_last),
    .O_s_ready(ready_b), .O_tx_d(txd_b), .O_tx_en(en_b), .O_tx_er(er_b), .O_busy(busy_b),
    .O_frame_cnt(fcnt_b), .O_abort_cnt(acnt_b)
  );

  logic       ready_m, en_m, er_m, busy_m;
  logic [3:0] txd_m;
  assign ready_m = sel ? ready_b : ready_a;
  assign en_m    = sel ? en_b    : en_a;
  assign er_m    = sel ? er_b    : er_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign txd_m   = sel ? txd_b   : txd_a;

  int checks = 0;
  int errors = 0;

  // Trace entries: [6]=busy [5]=tx_en [4]=tx_er [3:0]=tx_d
  logic [6:0]  tr[$];
  bit          cap_on = 1'b0;
  int          rd;
  logic [8:0]  stream_q[$];
  logic [7:0]  pl[$];
  logic [7:0]  pl1[$];
  logic [7:0]  pl2[$];
  logic [3:0]  exp_nib[$];
  logic [31:0] last_fcs;
  int          last_len;
  int          gap_low, gap_busy;

  always @(negedge clk) begin
    if (cap_on) tr.push_back({busy_m, en_m, er_m, txd_m});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Byte-wise reflected CRC-32 register (no final inversion).
  function automatic logic [31:0] crc_bytes(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h000000, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected on-wire nibble sequence of a good frame built from pl.
  task automatic build_exp(input int min_pay);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    fr = pl;
    while (fr.size() < min_pay) fr.push_back(8'h00);
    fcs = ~crc_bytes(fr);
    exp_nib.delete();
    repeat (15) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    foreach (fr[i]) begin
      exp_nib.push_back(fr[i][3:0]);
      exp_nib.push_back(fr[i][7:4]);
    end
    for (int i = 0; i < 8; i++) exp_nib.push_back(fcs[4*i +: 4]);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic append_stream();
    foreach (pl[i]) stream_q.push_back({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]});
  endtask

  task automatic start_capture();
    tr.delete();
    rd = 0;
    cap_on = 1'b1;
  endtask

  // Present stream_q with valid high; optionally drop valid for the one
  // cycle in which byte index drop_at would be consumed.
  task automatic send_stream(input int drop_at, input int max_cycles);
    int idx;
    int cyc;
    bit dropped;
    bit take;
    idx = 0; cyc = 0; dropped = 1'b0;
    while (idx < stream_q.size() && cyc < max_cycles) begin
      s_data  = stream_q[idx][7:0];
      s_last  = stream_q[idx][8];
      s_valid = 1'b1;
      @(negedge clk);
      if (idx == drop_at && !dropped && ready_m) begin
        s_valid = 1'b0;
        dropped = 1'b1;
      end
      take = s_valid && ready_m;
      @(posedge clk);
      #1;
      cyc++;
      if (take) idx++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("stream_consumed", idx, stream_q.size());
  endtask

  task automatic wait_idle(input int max_cycles);
    int c;
    int quiet;
    c = 0; quiet = 0;
    while (quiet < 3 && c < max_cycles) begin
      @(negedge clk);
      c++;
      quiet = busy_m ? 0 : quiet + 1;
    end
    chk("idle_reached", (quiet >= 3) ? 1 : 0, 1);
    cap_on = 1'b0;
  endtask

  // Check the next tx_en run in the trace against exp_nib. For an aborted
  // frame only the first data_nibs nibbles are sent, then two TX_ER cycles.
  task automatic check_run(input string tag, input int data_nibs, input bit aborted);
    int len, nm, ab, lim;
    logic [7:0] rx[$];
    len = 0; nm = 0; ab = 0;
    while (rd < tr.size() && tr[rd][5] !== 1'b1) rd++;
    while (rd + len < tr.size() && tr[rd+len][5] === 1'b1) len++;
    last_len = len;
    lim = aborted ? data_nibs : exp_nib.size();
    chk({tag, "_en_len"}, len, aborted ? data_nibs + 2 : exp_nib.size());
    for (int i = 0; i < len && i < lim; i++)
      if (tr[rd+i][3:0] !== exp_nib[i] || tr[rd+i][4] !== 1'b0) nm++;
    chk({tag, "_nibbles_bad"}, nm, 0);
    if (aborted) begin
      for (int i = data_nibs; i < len; i++)
        if (tr[rd+i][4] === 1'b1 && tr[rd+i][3:0] === 4'h0) ab++;
      chk({tag, "_abort_er_cycles"}, ab, 2);
    end else begin
      for (int i = 16; i + 1 < len; i += 2) rx.push_back({tr[rd+i+1][3:0], tr[rd+i][3:0]});
      chk({tag, "_rx_residue"}, crc_bytes(rx), 32'hDEBB20E3);
      last_fcs = 32'h0;
      if (len >= 8)
        for (int i = 0; i < 8; i++) last_fcs[4*i +: 4] = tr[rd+len-8+i][3:0];
    end
    rd += len;
  endtask

  // Count idle samples from rd up to the next tx_en (or end of trace).
  task automatic count_gap();
    gap_low = 0; gap_busy = 0;
    while (rd + gap_low < tr.size() && tr[rd+gap_low][5] !== 1'b1) begin
      if (tr[rd+gap_low][6] === 1'b1) gap_busy++;
      gap_low++;
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", en_a, 0);
    chk("rst_tx_er", er_a, 0);
    chk("rst_tx_d", txd_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_cnt", fcnt_a, 0);
    chk("rst_abort_cnt", acnt_a, 0);
    chk("rst_b_outs", {busy_b, en_b, er_b, ready_b, txd_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: "123456789" with padding disabled
    sel = 1'b1;
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    build_exp(0);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(-1, 200);
    wait_idle(200);
    check_run("t1", 0, 1'b0);
    chk("t1_fcs", last_fcs, 32'hCBF43926);
    count_gap();
    chk("t1_ipg_len", gap_busy, 24);
    chk("t1_frame_cnt", fcnt_b, 1);

    // 2: single byte 0xAA, padded to 60 bytes
    sel = 1'b0;
    pl.delete(); pl.push_back(8'hAA);
    build_exp(60);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(-1, 100);
    wait_idle(400);
    check_run("t2", 0, 1'b0);
    chk("t2_en_cycles", last_len, 144);
    chk("t2_frame_cnt", fcnt_a, 1);

    // 3: two 64-byte frames, valid held high throughout
    rand_pl(64); pl1 = pl;
    rand_pl(64); pl2 = pl;
    stream_q.delete();
    pl = pl1; append_stream();
    pl = pl2; append_stream();
    start_capture();
    send_stream(-1, 1000);
    wait_idle(400);
    pl = pl1; build_exp(60);
    check_run("t3a", 0, 1'b0);
    count_gap();
    chk("t3_gap", gap_low, 25);
    pl = pl2; build_exp(60);
    check_run("t3b", 0, 1'b0);
    chk("t3_frame_cnt", fcnt_a, 3);

    // 4: underrun at byte 10 of a 30-byte frame
    rand_pl(30);
    build_exp(60);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(10, 400);
    wait_idle(400);
    check_run("t4", 16 + 20, 1'b1);
    count_gap();
    chk("t4_no_more_tx", rd + gap_low, tr.size());
    chk("t4_abort_cnt", acnt_a, 1);
    chk("t4_frame_cnt", fcnt_a, 3);

    // 5: 1515-byte frame aborts after the last byte, then a normal frame
    rand_pl(1515);
    build_exp(60);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(-1, 5000);
    wait_idle(400);
    check_run("t5", 16 + 2 * 1514, 1'b1);
    chk("t5_en_cycles", last_len, 3046);
    count_gap();
    chk("t5_no_more_tx", rd + gap_low, tr.size());
    chk("t5_abort_cnt", acnt_a, 2);
    rand_pl(20);
    build_exp(60);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(-1, 200);
    wait_idle(400);
    check_run("t5n", 0, 1'b0);
    chk("t5_frame_cnt", fcnt_a, 4);

    // 6: reset pulse in the middle of DATA
    s_data = 8'h5A; s_last = 1'b0; s_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_tx_en", en_a, 0);
    chk("t6_tx_er", er_a, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_counters", {fcnt_a, acnt_a}, 0);
    rand_pl(40);
    build_exp(60);
    stream_q.delete(); append_stream();
    start_capture();
    send_stream(-1, 200);
    wait_idle(400);
    check_run("t6n", 0, 1'b0);
    chk("t6_frame_cnt", fcnt_a, 1);
    chk("t6_abort_cnt", acnt_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
